ofs_fim_pcie_ss_tx_pkt_arb: RTL and testbench
=============================================

Name: ofs_fim_pcie_ss_tx_pkt_arb

Overview:
Packet-level round-robin arbiter that merges NUM_PORTS in-band-header PCIe SS AXI-S TX streams into the single TX stream consumed by the FIM TX side-band pipeline. It sits directly upstream of that pipeline's in-band TX input, in the FIM clock domain. A grant is held for a whole packet, so packets are never interleaved. The output is decoupled by a 2-entry skid buffer.

Parameters:
NUM_PORTS, 2, number of input streams (2..8)
TDATA_WIDTH, 512, data width per stream
TKEEP_WIDTH, TDATA_WIDTH/8, byte-enable width
TUSER_WIDTH, 10, tuser_vendor width, passed through unchanged
PORT_ID_W, (NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1), width of the granted-port tag

Ports:
clk  in  1  FIM clock
rst_n  in  1  asynchronous active-low reset
in_tvalid  in  NUM_PORTS  per-port valid
in_tdata  in  NUM_PORTS*TDATA_WIDTH  per-port data; port i occupies slice i
in_tkeep  in  NUM_PORTS*TKEEP_WIDTH  per-port keep
in_tlast  in  NUM_PORTS  per-port end-of-packet
in_tuser_vendor  in  NUM_PORTS*TUSER_WIDTH  per-port tuser
in_tready  out  NUM_PORTS  per-port ready
out_tvalid  out  1  merged valid
out_tdata  out  TDATA_WIDTH  merged data
out_tkeep  out  TKEEP_WIDTH  merged keep
out_tlast  out  1  merged end-of-packet
out_tuser_vendor  out  TUSER_WIDTH  merged tuser
out_port_id  out  PORT_ID_W  source port of the current output beat
out_tready  in  1  downstream ready

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: out_tvalid=0, in_tready=0, skid occupancy=0, state=IDLE, rr_ptr=0. out_tdata, out_tkeep, out_tuser_vendor and out_port_id are don't-care.
- Skid buffer:
  - 2 entries; has_space = occupancy < 2, evaluated from registered occupancy.
  - out_tvalid = occupancy > 0; out_* is driven from the head entry.
  - Latency from an accepted input beat to out_tvalid is exactly 1 cycle.
  - A simultaneous push and pop leaves occupancy unchanged, and beat order is preserved.
- State machine, IDLE / LOCKED:
  - IDLE: sel = first port with in_tvalid set, searching rr_ptr, rr_ptr+1, ... mod NUM_PORTS. in_tready[sel] = has_space; all other ports see in_tready=0. If no port is valid, all in_tready=0.
  - IDLE, accepted beat with tlast=0: go to LOCKED with lock_port=sel.
  - IDLE, accepted single-beat packet (tlast=1): stay in IDLE; rr_ptr = sel+1 mod NUM_PORTS.
  - LOCKED: in_tready[lock_port] = has_space; all other ports see 0. lock_port's in_tvalid is not required to stay high between beats; the grant is held regardless.
  - LOCKED, accepted tlast beat: go to IDLE; rr_ptr = lock_port+1 mod NUM_PORTS.
- Zero bubble: arbitration is combinational in IDLE, so back-to-back packets from different ports need no idle cycle while out_tready=1.
- in_tready may depend combinationally on in_tvalid in IDLE. out_tvalid never depends combinationally on out_tready.
- Once out_tvalid is asserted, out_* stay stable until the beat is accepted (AXI-S rule).
- out_port_id is stored per skid entry alongside the data.
- NUM_PORTS=1: degenerates to the skid buffer; out_port_id is always 0.
- rr_ptr wraps from NUM_PORTS-1 to 0.
- Reset mid-packet: the buffer is flushed and the partial packet is dropped. Upstream sources share the same reset and restart on packet boundaries.

Optional Feature:
Macro: OFS_FIM_PCIE_SS_TX_ARB_STATS_EN.
- Defined: adds output pkt_count of width NUM_PORTS*32. Entry i is a free-running 32-bit counter of packets accepted from port i (incremented on each accepted tlast beat), wrapping 0xFFFFFFFF -> 0. It resets to 0 and does not saturate.
- Undefined: the port and counters are absent. Arbitration behaviour is identical in both cases.

Test Plan:
1. Ports 0 and 1 each hold a 3-beat packet, out_tready=1 -> output is P0 beats 0..2 then P1 beats 0..2, with no gap between tlast and the next beat; out_port_id goes 0,0,0,1,1,1; rr_ptr ends at 0.
2. Port 1 continuously offers single-beat packets; port 0 offers one packet at cycle 5 -> port 0's packet appears within 2 packets of its request; order alternates 1,0,1.
3. P0 4-beat packet with in_tvalid[0] dropped for 2 cycles mid-packet while port 1 is valid -> no port 1 beat is emitted until P0's tlast is output.
4. out_tready held 0 for 10 cycles during a stream -> exactly 2 beats are buffered, then in_tready=0; out_* stay stable; after release, all beats arrive in order with none lost or duplicated.
5. Assert rst_n=0 mid-packet (beat 2 of 4) -> out_tvalid=0 and in_tready=0 asynchronously; after release the next packet from rr_ptr=0 is output cleanly.
6. With OFS_FIM_PCIE_SS_TX_ARB_STATS_EN defined, send 5 packets on port 0 and 3 on port 1 -> pkt_count reads 5 and 3.

Source files
------------

// File: rtl/ofs_fim_pcie_ss_tx_pkt_arb.sv
// Purpose: packet-level round-robin merge of NUM_PORTS in-band-header AXI-S TX streams into one stream.
// Latency: 1 cycle from an accepted input beat to out_tvalid (2-entry skid buffer on the output).
// Backpressure: only the granted port sees in_tready, equal to skid space (occupancy < 2); others see 0.
//
// Ports: clk / rst_n (async active-low); in_* are NUM_PORTS AXI-S streams, port i in slice i;
//        out_* is the merged AXI-S stream, out_port_id tags the source port of each beat.
// Optional: define OFS_FIM_PCIE_SS_TX_ARB_STATS_EN to add pkt_count (32-bit per-port packet counters).
module ofs_fim_pcie_ss_tx_pkt_arb #(
    parameter int NUM_PORTS   = 2,
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int TUSER_WIDTH = 10,
    parameter int PORT_ID_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               in_tvalid,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]   in_tdata,
    input  logic [NUM_PORTS*TKEEP_WIDTH-1:0]   in_tkeep,
    input  logic [NUM_PORTS-1:0]               in_tlast,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0]   in_tuser_vendor,
    output logic [NUM_PORTS-1:0]               in_tready,
    output logic                               out_tvalid,
    output logic [TDATA_WIDTH-1:0]             out_tdata,
    output logic [TKEEP_WIDTH-1:0]             out_tkeep,
    output logic                               out_tlast,
    output logic [TUSER_WIDTH-1:0]             out_tuser_vendor,
    output logic [PORT_ID_W-1:0]               out_port_id,
    input  logic                               out_tready
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]            pkt_count
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    // One skid entry: the beat plus the port it came from.
    typedef struct packed {
        logic [TDATA_WIDTH-1:0] dat;
        logic [TKEEP_WIDTH-1:0] keep;
        logic                   last;
        logic [TUSER_WIDTH-1:0] user;
        logic [PORT_ID_W-1:0]   port;
    } beat_t;

    localparam logic [PORT_ID_W-1:0] LAST_PORT = PORT_ID_W'(NUM_PORTS - 1);

    function automatic logic [PORT_ID_W-1:0] next_port(input logic [PORT_ID_W-1:0] p);
        return (p == LAST_PORT) ? '0 : p + PORT_ID_W'(1);
    endfunction

    state_t               state, state_nxt;
    logic [PORT_ID_W-1:0] lock_port, lock_port_nxt;
    logic [PORT_ID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [PORT_ID_W-1:0] arb_sel, arb_cand, cur_port;
    logic                 arb_vld;
    int                   arb_idx;

    logic [1:0]           occ;
    logic                 rd_ptr, wr_ptr;
    logic                 has_space, push, pop;
    beat_t                skid_mem [2];
    beat_t                in_beat, head;

    // Space is gated by rst_n so in_tready drops the instant reset asserts,
    // not only once the occupancy flop has been cleared.
    assign has_space = rst_n && (occ < 2'd2);

    // Round-robin search starting at rr_ptr. Walking the offsets from the far
    // end down lets the closest valid port (lowest offset) win last.
    always_comb begin
        arb_sel  = rr_ptr;
        arb_vld  = 1'b0;
        arb_idx  = 0;
        arb_cand = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
            arb_cand = PORT_ID_W'(arb_idx);
            if (in_tvalid[arb_cand]) begin
                arb_sel = arb_cand;
                arb_vld = 1'b1;
            end
        end
    end

    // While LOCKED the grant stays on lock_port even if its valid drops.
    assign cur_port = (state == LOCKED) ? lock_port : arb_sel;

    always_comb begin
        in_beat.dat  = in_tdata[cur_port*TDATA_WIDTH +: TDATA_WIDTH];
        in_beat.keep = in_tkeep[cur_port*TKEEP_WIDTH +: TKEEP_WIDTH];
        in_beat.last = in_tlast[cur_port];
        in_beat.user = in_tuser_vendor[cur_port*TUSER_WIDTH +: TUSER_WIDTH];
        in_beat.port = cur_port;
    end

    // With no valid port in IDLE cur_port's valid is low, so no push occurs.
    assign push = has_space && in_tvalid[cur_port];
    assign pop  = (occ != 2'd0) && out_tready;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lock_port <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            lock_port <= lock_port_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt     = state;
        lock_port_nxt = lock_port;
        rr_ptr_nxt    = rr_ptr;
        if (push) begin
            if (state == IDLE) begin
                if (in_beat.last) begin
                    rr_ptr_nxt = next_port(arb_sel);
                end else begin
                    state_nxt     = LOCKED;
                    lock_port_nxt = arb_sel;
                end
            end else if (in_beat.last) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = next_port(lock_port);
            end
        end
    end

    // FSM: outputs
    always_comb begin
        in_tready = '0;
        if (state == LOCKED || arb_vld) begin
            in_tready[cur_port] = has_space;
        end
    end

    // Skid buffer control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Skid storage carries no reset: contents are don't-care while occ == 0.
    always_ff @(posedge clk) begin
        if (push) skid_mem[wr_ptr] <= in_beat;
    end

    assign head             = skid_mem[rd_ptr];
    assign out_tvalid       = (occ != 2'd0);
    assign out_tdata        = head.dat;
    assign out_tkeep        = head.keep;
    assign out_tlast        = head.last;
    assign out_tuser_vendor = head.user;
    assign out_port_id      = head.port;

`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
    logic [31:0] pkt_cnt [NUM_PORTS];

    // Free-running, wraps at 2^32; bumps on each accepted tlast beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) pkt_cnt[i] <= '0;
        end else if (push && in_beat.last) begin
            pkt_cnt[cur_port] <= pkt_cnt[cur_port] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign pkt_count[g*32 +: 32] = pkt_cnt[g];
    end
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_pkt_arb.sv
// Purpose: bench for ofs_fim_pcie_ss_tx_pkt_arb (3 ports, 32-bit data), packet-level reference model.
// Latency: expects out_tvalid exactly one cycle after the first accepted beat.
// Backpressure: drives random/held out_tready and random source gaps.
module tb_ofs_fim_pcie_ss_tx_pkt_arb;

    localparam int NP = 3;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 10;
    localparam int PW = 2;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    typedef struct packed {
        beat_t         b;
        logic [PW-1:0] port;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [NP-1:0]    in_tvalid;
    logic [NP*DW-1:0] in_tdata;
    logic [NP*KW-1:0] in_tkeep;
    logic [NP-1:0]    in_tlast;
    logic [NP*UW-1:0] in_tuser_vendor;
    logic [NP-1:0]    in_tready;
    logic             out_tvalid;
    logic [DW-1:0]    out_tdata;
    logic [KW-1:0]    out_tkeep;
    logic             out_tlast;
    logic [UW-1:0]    out_tuser_vendor;
    logic [PW-1:0]    out_port_id;
    logic             out_tready;
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
    logic [NP*32-1:0] pkt_count;
`endif

    ofs_fim_pcie_ss_tx_pkt_arb #(
        .NUM_PORTS   (NP),
        .TDATA_WIDTH (DW),
        .TKEEP_WIDTH (KW),
        .TUSER_WIDTH (UW),
        .PORT_ID_W   (PW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_tvalid        (in_tvalid),
        .in_tdata         (in_tdata),
        .in_tkeep         (in_tkeep),
        .in_tlast         (in_tlast),
        .in_tuser_vendor  (in_tuser_vendor),
        .in_tready        (in_tready),
        .out_tvalid       (out_tvalid),
        .out_tdata        (out_tdata),
        .out_tkeep        (out_tkeep),
        .out_tlast        (out_tlast),
        .out_tuser_vendor (out_tuser_vendor),
        .out_port_id      (out_port_id),
        .out_tready       (out_tready)
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
        ,
        .pkt_count        (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass, n_total, n_fail;
    beat_t       src [NP][$];      // beats each source still has to send
    exp_t        exp_q [$];        // beats accepted by the arbiter, not yet seen on the output
    int          out_ids [$];      // source port of every beat leaving the output
    bit          offering [NP];
    int          hold [NP];
    int unsigned pkt_cnt [NP];
    int unsigned gap_pct, rdy_pct;
    bit          stall;
    bit          in_pkt;
    int          lock, rr;
    int          beats_in;
    logic [NP-1:0] rdy_seen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.dat  = $urandom;
            b.keep = KW'($urandom);
            b.last = (i == len - 1);
            b.user = UW'($urandom);
            src[p].push_back(b);
        end
    endtask

    function automatic int pending();
        int s = exp_q.size();
        for (int p = 0; p < NP; p++) s += src[p].size();
        return s;
    endfunction

    function automatic int seq_code();
        int c = 0;
        foreach (out_ids[i]) c = c * 10 + out_ids[i] + 1;
        return c;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            src[p].delete();
            offering[p] = 1'b0;
            hold[p]     = 0;
            pkt_cnt[p]  = 0;
        end
        in_pkt = 1'b0;
        lock   = 0;
        rr     = 0;
    endtask

    // AXI-S sources: once a beat is offered it is held until accepted.
    task automatic drive();
        beat_t b;
        for (int p = 0; p < NP; p++) begin
            if (!offering[p] && src[p].size() > 0) begin
                if (hold[p] > 0) hold[p]--;
                else if ($urandom_range(99) >= gap_pct) offering[p] = 1'b1;
            end
            b = (src[p].size() > 0) ? src[p][0] : '0;
            in_tvalid[p]                  = offering[p];
            in_tdata[p*DW +: DW]          = b.dat;
            in_tkeep[p*KW +: KW]          = b.keep;
            in_tlast[p]                   = b.last;
            in_tuser_vendor[p*UW +: UW]   = b.user;
        end
        out_tready = !stall && ($urandom_range(99) < rdy_pct);
    endtask

    // One clock: drive at negedge, check 1 ns later, advance model at posedge.
    task automatic cycle();
        logic [NP-1:0] exp_rdy, hs;
        bit   pop;
        int   g, p;
        exp_t e;
        beat_t b;
        drive();
        #1;
        g = -1;
        if (in_pkt) g = lock;
        else begin
            for (int k = 0; k < NP; k++) begin
                p = (rr + k) % NP;
                if (g < 0 && in_tvalid[p]) g = p;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = (exp_q.size() < 2);
        chk("in_tready", 128'(in_tready), 128'(exp_rdy));
        chk("out_tvalid", 128'(out_tvalid), 128'(exp_q.size() > 0));
        if (exp_q.size() > 0)
            chk("out_beat", 128'({out_tdata, out_tkeep, out_tlast, out_tuser_vendor, out_port_id}),
                128'(exp_q[0]));
        rdy_seen = in_tready;
        hs  = in_tvalid & in_tready;
        pop = out_tvalid && out_tready;
        @(posedge clk);
        if (pop && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            out_ids.push_back(int'(e.port));
        end
        for (int q = 0; q < NP; q++) begin
            if (hs[q] && src[q].size() > 0) begin
                b = src[q].pop_front();
                offering[q] = 1'b0;
                e.b    = b;
                e.port = PW'(q);
                exp_q.push_back(e);
                beats_in++;
                if (b.last) begin
                    in_pkt = 1'b0;
                    rr     = (q + 1) % NP;
                    pkt_cnt[q]++;
                end else begin
                    in_pkt = 1'b1;
                    lock   = q;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (pending() > 0 && n < 400) begin
            cycle();
            n++;
        end
        chk(tag, 128'(pending()), 128'(0));
    endtask

    // Reset asserted between clock edges: outputs must fall without a clock.
    task automatic apply_reset();
        drive();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_tvalid", 128'(out_tvalid), 128'(0));
        chk("rst_in_tready", 128'(in_tready), 128'(0));
        model_reset();
        in_tvalid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, k, req_at, win, base;
        bit held;
        n_pass = 0; n_total = 0; n_fail = 0; beats_in = 0;
        gap_pct = 0; rdy_pct = 100; stall = 1'b0;
        rst_n = 1'b0;
        in_tvalid = '1; in_tdata = '0; in_tkeep = '0; in_tlast = '0; in_tuser_vendor = '0;
        out_tready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_tvalid", 128'(out_tvalid), 128'(0));
        chk("reset_in_tready", 128'(in_tready), 128'(0));
        in_tvalid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: two 3-beat packets back to back, no bubble between them
        out_ids.delete();
        add_pkt(0, 3);
        add_pkt(1, 3);
        n = 0;
        while (out_ids.size() < 6 && n < 20) begin
            cycle();
            n++;
        end
        chk("t1_cycles", 128'(n), 128'(7));
        chk("t1_order", 128'(seq_code()), 128'(111222));

        // 2: port 1 streams single-beat packets, port 0 joins at cycle 5
        out_ids.delete();
        req_at = 0;
        for (int c = 0; c < 12; c++) begin
            if (src[1].size() == 0) add_pkt(1, 1);
            if (c == 5) begin
                add_pkt(0, 1);
                req_at = out_ids.size();
            end
            cycle();
        end
        drain("t2_drained");
        k = -1;
        foreach (out_ids[i]) if (k < 0 && out_ids[i] == 0) k = i;
        win = 999;
        if (k >= 1 && k + 1 < out_ids.size())
            win = (out_ids[k-1] + 1) * 100 + (out_ids[k] + 1) * 10 + out_ids[k+1] + 1;
        chk("t2_alternate", 128'(win), 128'(212));
        chk("t2_wait", 128'((k >= 0) && (k - req_at <= 2)), 128'(1));

        // 3: port 0 drops valid for 2 cycles mid-packet, port 1 must wait
        out_ids.delete();
        add_pkt(0, 4);
        cycle();
        add_pkt(1, 2);
        held = 1'b0;
        n = 0;
        while (pending() > 0 && n < 40) begin
            if (!held && src[0].size() == 2) begin
                hold[0] = 2;
                held = 1'b1;
            end
            cycle();
            n++;
        end
        chk("t3_drained", 128'(pending()), 128'(0));
        chk("t3_order", 128'(seq_code()), 128'(111122));

        // 4: downstream stalled for 10 cycles
        out_ids.delete();
        add_pkt(0, 4);
        add_pkt(1, 3);
        base = beats_in;
        stall = 1'b1;
        repeat (10) cycle();
        chk("t4_buffered", 128'(beats_in - base), 128'(2));
        chk("t4_in_tready_low", 128'(rdy_seen), 128'(0));
        chk("t4_out_held", 128'(out_ids.size()), 128'(0));
        stall = 1'b0;
        drain("t4_drained");
        chk("t4_order", 128'(seq_code()), 128'(1111222));

        // 5: reset in the middle of a 4-beat packet
        add_pkt(0, 4);
        add_pkt(1, 2);
        n = 0;
        while (src[0].size() > 2 && n < 20) begin
            cycle();
            n++;
        end
        apply_reset();
        out_ids.delete();
        add_pkt(1, 2);
        add_pkt(0, 2);
        drain("t5_drained");
        chk("t5_order", 128'(seq_code()), 128'(1122));

        // random traffic with source gaps and random backpressure
        gap_pct = 30;
        rdy_pct = 70;
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NP; p++)
                if (src[p].size() < 4 && $urandom_range(99) < 25) add_pkt(p, int'($urandom_range(4, 1)));
            cycle();
        end
        rdy_pct = 100;
        drain("rand_drained");
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
        for (int p = 0; p < NP; p++)
            chk("rand_pkt_count", 128'(pkt_count[p*32 +: 32]), 128'(pkt_cnt[p]));
`endif

        // 6: 5 packets on port 0, 3 on port 1 after a fresh reset
        gap_pct = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) add_pkt(0, int'($urandom_range(3, 1)));
        for (int i = 0; i < 3; i++) add_pkt(1, int'($urandom_range(3, 1)));
        drain("t6_drained");
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
        chk("t6_pkt_count0", 128'(pkt_count[31:0]), 128'(5));
        chk("t6_pkt_count1", 128'(pkt_count[63:32]), 128'(3));
        chk("t6_pkt_count2", 128'(pkt_count[95:64]), 128'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
